adsr_envelope: RTL and testbench
================================

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000: clock cycles per envelope tick, always >= 1.
REQ-002 SHALL have parameter ATTACK_INC, default 16'd655: level increment per tick in ATTACK.
REQ-003 SHALL have parameter DECAY_DEC, default 16'd328: level decrement per tick in DECAY.
REQ-004 SHALL have parameter SUSTAIN_LEVEL, default 8'hC0: sustain floor, compared against level[15:8] (floor = {SUSTAIN_LEVEL, 8'h00}).
REQ-005 SHALL have parameter RELEASE_DEC, default 16'd164: level decrement per tick in RELEASE.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port i_gate, input, 1 bit: note on (1) or off (0), synchronous to i_clk.
REQ-009 SHALL have port i_sample, input, 9 bits: unsigned waveform sample (sine-table output), 0..511.
REQ-010 SHALL have port i_sample_valid, input, 1 bit: i_sample is qualified this cycle.
REQ-011 SHALL have port o_compare, output, 9 bits: scaled sample, fed to the pwm i_compare input.
REQ-012 SHALL have port o_compare_valid, output, 1 bit: o_compare updated this cycle.
REQ-013 SHALL have port o_level, output, 8 bits: the current envelope level[15:8].
REQ-014 SHALL have port o_state, output, 3 bits: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-015 SHALL have port o_busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-016 SHALL keep a free-running tick counter 0..TICK_DIV-1 that wraps to 0; tick asserts for one cycle when the counter equals TICK_DIV-1.
REQ-017 SHALL hold a 16-bit level register and change it only on tick cycles, except under REQ-024.
REQ-018 SHALL register i_gate each cycle; rise = i_gate & ~gate_d, and gate_d resets to 0.
REQ-019 SHALL enter ATTACK on rise from any state (retrigger), keeping the current level.
REQ-020 SHALL enter RELEASE when i_gate==0 in ATTACK, DECAY or SUSTAIN.
REQ-021 SHALL in ATTACK on tick: level = min(level+ATTACK_INC, 16'hFFFF), using a 17-bit sum; on reaching 16'hFFFF, enter DECAY on the same edge.
REQ-022 SHALL in DECAY on tick: level = max(level-DECAY_DEC, floor), underflow-safe; on reaching floor, enter SUSTAIN on the same edge; if the level is already <= floor, set level = floor and enter SUSTAIN.
REQ-023 SHALL in SUSTAIN hold the level; in RELEASE on tick: level = max(level-RELEASE_DEC, 0); on reaching 0, enter IDLE; in IDLE level SHALL stay 0.
REQ-024 SHALL give a REQ-019/REQ-020 transition priority over a same-cycle tick: the state changes and the level is unchanged that cycle.
REQ-025 SHALL when i_sample_valid=1 at cycle N set o_compare = (i_sample*level[15:8])[16:8] (17-bit product) and o_compare_valid=1 at N+1, using the cycle-N level; otherwise o_compare holds its value and o_compare_valid=0.
REQ-026 SHALL drive o_level, o_state and o_busy from registers with no combinational input-to-output path.

Reset
REQ-027 SHALL on i_reset=1 at a clock edge, including mid-note, set state IDLE, level 0, tick counter 0, gate_d 0, o_compare 0, o_compare_valid 0, o_level 0, o_busy 0.
REQ-028 SHALL, when i_gate is held 1 through reset, detect rise on the first cycle after reset and enter ATTACK.
REQ-029 SHALL ignore i_sample_valid while i_reset=1.

Verification (TICK_DIV=4, ATTACK_INC=16'h4000, DECAY_DEC=16'h2000, SUSTAIN_LEVEL=8'hC0, RELEASE_DEC=16'h4000)
REQ-030 SHALL cover full note: gate 0->1 and held -> ATTACK, level 4000/8000/C000/FFFF on successive ticks, DECAY at the 4th tick; DFFF, then C000 and SUSTAIN; after gate 1->0 -> RELEASE, 8000/4000/0000, IDLE, o_busy=0.
REQ-031 SHALL cover scaling: sample 9'h1FF valid with level FFFF -> next cycle o_compare=9'h1FD and valid=1; sample 9'h100 with level C000 -> 9'h0C0; with level 0 -> 0.
REQ-032 SHALL cover retrigger: gate falls in DECAY at level DFFF, rises 2 cycles later -> ATTACK from DFFF, next tick level FFFF, then DECAY.
REQ-033 SHALL cover simultaneous events: gate falls on the tick cycle in SUSTAIN -> RELEASE with level still C000 that cycle; first decrement on the next tick.
REQ-034 SHALL cover mid-note reset: i_reset pulse in ATTACK at level 8000 -> next cycle IDLE, level 0, outputs 0; gate still high -> ATTACK the cycle after reset deasserts.
REQ-035 SHALL cover TICK_DIV=1: tick every cycle; attack completes in 4 consecutive cycles.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR envelope generator. A free-running tick divider paces a 16-bit level
// through attack, decay, sustain and release. Each qualified waveform sample
// is scaled by the level's upper byte to drive a PWM compare value.
module adsr_envelope #(
    parameter int          TICK_DIV      = 25000,
    parameter logic [15:0] ATTACK_INC    = 16'd655,
    parameter logic [15:0] DECAY_DEC     = 16'd328,
    parameter logic [7:0]  SUSTAIN_LEVEL = 8'hC0,
    parameter logic [15:0] RELEASE_DEC   = 16'd164
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_gate,
    input  logic [8:0] i_sample,
    input  logic       i_sample_valid,
    output logic [8:0] o_compare,
    output logic       o_compare_valid,
    output logic [7:0] o_level,
    output logic [2:0] o_state,
    output logic       o_busy
);

    localparam int              CW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST   = CW'(TICK_DIV - 1);
    localparam logic [15:0]     FLOOR_LEVEL = {SUSTAIN_LEVEL, 8'h00};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     level_reg, level_next;
    logic [CW-1:0]   tick_cnt_reg;
    logic            tick;
    logic            gate_d_reg;
    logic            rise;
    logic [16:0]     attack_sum;
    logic [8:0]      compare_reg;
    logic            compare_valid_reg;
    logic [16:0]     pp [9];
    logic [16:0]     product;

    assign tick = (tick_cnt_reg == TICK_LAST);
    assign rise = i_gate & ~gate_d_reg;

    // Tick divider: counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + CW'(1);
        end
    end

    // Gate delay for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            gate_d_reg <= 1'b0;
        end else begin
            gate_d_reg <= i_gate;
        end
    end

    // State and level registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            level_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
        end
    end

    // Next state/level: gate events win over a coincident tick and leave the level alone.
    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        attack_sum = {1'b0, level_reg} + {1'b0, ATTACK_INC};
        if (rise) begin
            state_next = ST_ATTACK;
        end else if (!i_gate && (state_reg == ST_ATTACK || state_reg == ST_DECAY ||
                                 state_reg == ST_SUSTAIN)) begin
            state_next = ST_RELEASE;
        end else if (tick) begin
            case (state_reg)
                ST_ATTACK: begin
                    if (attack_sum >= 17'h0FFFF) begin
                        level_next = 16'hFFFF;
                        state_next = ST_DECAY;
                    end else begin
                        level_next = attack_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    // Subtraction only evaluated as meaningful when above the floor.
                    if (level_reg <= FLOOR_LEVEL ||
                        (level_reg - FLOOR_LEVEL) <= DECAY_DEC) begin
                        level_next = FLOOR_LEVEL;
                        state_next = ST_SUSTAIN;
                    end else begin
                        level_next = level_reg - DECAY_DEC;
                    end
                end
                ST_SUSTAIN: begin
                    level_next = level_reg;
                end
                ST_RELEASE: begin
                    if (level_reg <= RELEASE_DEC) begin
                        level_next = 16'h0000;
                        state_next = ST_IDLE;
                    end else begin
                        level_next = level_reg - RELEASE_DEC;
                    end
                end
                ST_IDLE: begin
                    level_next = 16'h0000;
                end
                default: begin
                    level_next = 16'h0000;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Shift-and-add partial products of sample x level[15:8].
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_pp
            assign pp[gi] = i_sample[gi] ? ({9'd0, level_reg[15:8]} << gi) : 17'd0;
        end
    endgenerate

    // Sum partial products into the 17-bit product.
    always_comb begin
        product = 17'd0;
        for (int i = 0; i < 9; i++) begin
            product = product + pp[i];
        end
    end

    // Register the scaled sample; value holds when no sample is qualified.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            compare_reg       <= 9'd0;
            compare_valid_reg <= 1'b0;
        end else begin
            compare_valid_reg <= i_sample_valid;
            if (i_sample_valid) begin
                compare_reg <= 9'(product >> 8);
            end
        end
    end

    assign o_compare       = compare_reg;
    assign o_compare_valid = compare_valid_reg;
    assign o_level         = level_reg[15:8];
    assign o_state         = state_reg;
    assign o_busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Testbench for adsr_envelope: table-driven note, hand-written corner
// sequences and randomized stimulus against an arithmetic reference model.
module tb_adsr_envelope;

    localparam int TD    = 4;
    localparam int AINC  = 'h4000;
    localparam int DDEC  = 'h2000;
    localparam int FLOOR = 'hC000;
    localparam int RDEC  = 'h4000;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, gate, sv;
    logic [8:0] sample;
    logic [8:0] dut_cmp;
    logic       dut_cv;
    logic [7:0] dut_lvl;
    logic [2:0] dut_st;
    logic       dut_busy;

    logic       rst1, gate1, sv1;
    logic [8:0] sample1;
    logic [8:0] cmp1;
    logic       cv1;
    logic [7:0] lvl1;
    logic [2:0] st1;
    logic       busy1;

    adsr_envelope #(
        .TICK_DIV(4), .ATTACK_INC(16'h4000), .DECAY_DEC(16'h2000),
        .SUSTAIN_LEVEL(8'hC0), .RELEASE_DEC(16'h4000)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_gate(gate), .i_sample(sample),
        .i_sample_valid(sv), .o_compare(dut_cmp), .o_compare_valid(dut_cv),
        .o_level(dut_lvl), .o_state(dut_st), .o_busy(dut_busy)
    );

    adsr_envelope #(
        .TICK_DIV(1), .ATTACK_INC(16'h4000), .DECAY_DEC(16'h2000),
        .SUSTAIN_LEVEL(8'hC0), .RELEASE_DEC(16'h4000)
    ) dut1 (
        .i_clk(clk), .i_reset(rst1), .i_gate(gate1), .i_sample(sample1),
        .i_sample_valid(sv1), .o_compare(cmp1), .o_compare_valid(cv1),
        .o_level(lvl1), .o_state(st1), .o_busy(busy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_state, m_level, m_cnt, m_cmp;
    bit m_gd, m_cv;

    typedef struct {
        bit         gate;
        bit         sv;
        logic [8:0] sample;
        int         cyc;
        int         st;
        logic [7:0] lvl;
        bit         cv;
        logic [8:0] cmp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Envelope rules expressed with plain integer arithmetic.
    task automatic model_step();
        bit tick_now, rise_now;
        if (rst) begin
            m_state = 0; m_level = 0; m_cnt = 0; m_gd = 0; m_cmp = 0; m_cv = 0;
        end else begin
            tick_now = (m_cnt == TD - 1);
            m_cnt    = tick_now ? 0 : m_cnt + 1;
            rise_now = gate && !m_gd;
            m_gd     = gate;
            m_cv     = sv;
            if (sv) m_cmp = (int'(sample) * (m_level / 256)) / 256;
            if (rise_now) begin
                m_state = 1;
            end else if (!gate && m_state >= 1 && m_state <= 3) begin
                m_state = 4;
            end else if (tick_now) begin
                case (m_state)
                    1: if (m_level + AINC >= 65535) begin m_level = 65535; m_state = 2; end
                       else m_level = m_level + AINC;
                    2: if (m_level - DDEC <= FLOOR) begin m_level = FLOOR; m_state = 3; end
                       else m_level = m_level - DDEC;
                    4: if (m_level - RDEC <= 0) begin m_level = 0; m_state = 0; end
                       else m_level = m_level - RDEC;
                    0: m_level = 0;
                    default: ;
                endcase
            end
        end
    endtask

    // One clock: advance DUT and model, compare every main output.
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        chk("model_state", dut_st, m_state);
        chk("model_level", dut_lvl, m_level / 256);
        chk("model_busy", dut_busy, (m_state != 0));
        chk("model_cv", dut_cv, m_cv);
        chk("model_cmp", dut_cmp, m_cmp);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset(input bit g);
        rst = 1'b1; gate = g; sv = 1'b0; sample = 9'd0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic chk_main(input string tag, input int st, input int lvl);
        chk({tag, "_state"}, dut_st, st);
        chk({tag, "_level"}, dut_lvl, lvl);
        chk({tag, "_busy"}, dut_busy, (st != 0));
    endtask

    initial begin
        rst = 1'b1; gate = 1'b0; sv = 1'b0; sample = 9'd0;
        rst1 = 1'b1; gate1 = 1'b0; sv1 = 1'b0; sample1 = 9'd0;
        m_state = 0; m_level = 0; m_cnt = 0; m_cmp = 0; m_gd = 0; m_cv = 0;

        // Reset state
        do_reset(1'b0);
        chk_main("reset", 0, 0);
        chk("reset_cv", dut_cv, 0);
        chk("reset_cmp", dut_cmp, 0);
        $display("reset: state=%0d level=%0h busy=%0b", dut_st, dut_lvl, dut_busy);

        // Full note with scaling checks, counted in edges after reset.
        tbl[0]  = '{1'b1, 1'b0, 9'h000, 1, 1, 8'h00, 1'b0, 9'h000};
        tbl[1]  = '{1'b1, 1'b0, 9'h000, 3, 1, 8'h40, 1'b0, 9'h000};
        tbl[2]  = '{1'b1, 1'b0, 9'h000, 4, 1, 8'h80, 1'b0, 9'h000};
        tbl[3]  = '{1'b1, 1'b0, 9'h000, 4, 1, 8'hC0, 1'b0, 9'h000};
        tbl[4]  = '{1'b1, 1'b0, 9'h000, 4, 2, 8'hFF, 1'b0, 9'h000};
        tbl[5]  = '{1'b1, 1'b1, 9'h1FF, 1, 2, 8'hFF, 1'b1, 9'h1FD};
        tbl[6]  = '{1'b1, 1'b0, 9'h000, 3, 2, 8'hDF, 1'b0, 9'h1FD};
        tbl[7]  = '{1'b1, 1'b0, 9'h000, 4, 3, 8'hC0, 1'b0, 9'h1FD};
        tbl[8]  = '{1'b1, 1'b1, 9'h100, 1, 3, 8'hC0, 1'b1, 9'h0C0};
        tbl[9]  = '{1'b0, 1'b0, 9'h000, 1, 4, 8'hC0, 1'b0, 9'h0C0};
        tbl[10] = '{1'b0, 1'b0, 9'h000, 2, 4, 8'h80, 1'b0, 9'h0C0};
        tbl[11] = '{1'b0, 1'b0, 9'h000, 4, 4, 8'h40, 1'b0, 9'h0C0};
        tbl[12] = '{1'b0, 1'b0, 9'h000, 4, 0, 8'h00, 1'b0, 9'h0C0};
        tbl[13] = '{1'b0, 1'b1, 9'h100, 1, 0, 8'h00, 1'b1, 9'h000};
        for (int i = 0; i < 14; i++) begin
            gate = tbl[i].gate; sv = tbl[i].sv; sample = tbl[i].sample;
            run(tbl[i].cyc);
            chk_main($sformatf("vec%0d", i), tbl[i].st, int'(tbl[i].lvl));
            chk($sformatf("vec%0d_cv", i), dut_cv, tbl[i].cv);
            chk($sformatf("vec%0d_cmp", i), dut_cmp, tbl[i].cmp);
            $display("vec %0d: state=%0d level=%0h cv=%0b cmp=%0h", i, dut_st, dut_lvl, dut_cv, dut_cmp);
        end
        sv = 1'b0;

        // Retrigger out of a release that began in decay
        do_reset(1'b0);
        gate = 1'b1;
        run(20);
        chk_main("retrig_decay", 2, 'hDF);
        gate = 1'b0; step();
        chk_main("retrig_rel", 4, 'hDF);
        step();
        gate = 1'b1; step();
        chk_main("retrig_att", 1, 'hDF);
        step();
        chk_main("retrig_full", 2, 'hFF);
        $display("retrigger: state=%0d level=%0h", dut_st, dut_lvl);

        // Gate falls on a tick cycle in sustain
        do_reset(1'b0);
        gate = 1'b1;
        run(24);
        chk_main("simul_sus", 3, 'hC0);
        run(3);
        gate = 1'b0; step();
        chk_main("simul_rel", 4, 'hC0);
        run(3);
        chk_main("simul_hold", 4, 'hC0);
        step();
        chk_main("simul_dec", 4, 'h80);
        $display("simultaneous: state=%0d level=%0h", dut_st, dut_lvl);

        // Reset pulse mid-attack with gate held high
        do_reset(1'b0);
        gate = 1'b1;
        run(7);
        sv = 1'b1; sample = 9'h1FF; step();
        chk_main("midrst_pre", 1, 'h80);
        chk("midrst_pre_cmp", dut_cmp, 9'h07F);
        rst = 1'b1; step();
        chk_main("midrst_rst", 0, 0);
        chk("midrst_cv", dut_cv, 0);
        chk("midrst_cmp", dut_cmp, 0);
        rst = 1'b0; sv = 1'b0; step();
        chk_main("midrst_att", 1, 0);
        $display("mid-note reset: state=%0d level=%0h", dut_st, dut_lvl);

        // Randomized stimulus against the model
        do_reset(1'b0);
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            sv = 1'($urandom_range(0, 1));
            sample = 9'($urandom_range(0, 511));
            step();
        end
        $display("random: 1500 cycles, %0d compared so far", n_cmp);

        // TICK_DIV=1 instance: attack completes in four consecutive cycles
        rst = 1'b1; gate = 1'b0; sv = 1'b0;
        rst1 = 1'b1; gate1 = 1'b0; step();
        rst1 = 1'b0; gate1 = 1'b1; step();
        chk("td1_start_state", st1, 1);
        chk("td1_start_level", lvl1, 8'h00);
        step(); chk("td1_l1", lvl1, 8'h40);
        step(); chk("td1_l2", lvl1, 8'h80);
        step(); chk("td1_l3", lvl1, 8'hC0);
        step();
        chk("td1_l4", lvl1, 8'hFF);
        chk("td1_decay", st1, 2);
        chk("td1_busy", busy1, 1);
        $display("tick_div1: state=%0d level=%0h", st1, lvl1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
